// File: rtl/fifo_rd_packer.sv
// Read-domain FIFO consumer: pops WIDTH-bit entries through a first-word-fall-through port
// and packs RATIO of them into one registered output word; flush emits a partial word.
module fifo_rd_packer #(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
) (
  input  logic                      rclk,
  input  logic                      rrstn,
  input  logic [WIDTH-1:0]          fifo_rdata,
  input  logic                      fifo_empty,
  output logic                      fifo_ren,
  input  logic                      flush,
  output logic [WIDTH*RATIO-1:0]    out_data,
  output logic [$clog2(RATIO):0]    out_cnt,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int CW = $clog2(RATIO) + 1;

  logic [RATIO-1:0][WIDTH-1:0] acc, acc_d;
  logic [CW-1:0]               lane_cnt, lane_cnt_d;
  logic                        flush_pend, flush_pend_d;
  logic                        word_done, out_free, xfer;

  // Handshake: a word moves downstream on any rising edge where out_valid && out_ready;
  // out_data/out_cnt hold while out_valid && !out_ready, and valid never drops unaccepted.
  assign word_done = (lane_cnt == CW'(RATIO)) || (flush_pend && (lane_cnt != '0));
  assign out_free  = !out_valid || out_ready;
  assign xfer      = word_done && out_free;

  // A full accumulator may still pop when its word leaves this cycle (lane 0 of the next).
  assign fifo_ren  = rrstn && !fifo_empty && !flush && !flush_pend &&
                     ((lane_cnt < CW'(RATIO)) || xfer);

  always_comb begin
    acc_d      = acc;
    lane_cnt_d = lane_cnt;
    if (fifo_ren) begin
      if (xfer) begin
        acc_d      = '0;
        acc_d[0]   = fifo_rdata;
        lane_cnt_d = CW'(1);
      end else begin
        acc_d[lane_cnt[CW-2:0]] = fifo_rdata;
        lane_cnt_d              = lane_cnt + CW'(1);
      end
    end else if (xfer) begin
      acc_d      = '0;
      lane_cnt_d = '0;
    end
  end

  // An empty accumulator has nothing to emit, so a pending flush simply retires.
  always_comb begin
    flush_pend_d = flush;
    if (flush_pend) flush_pend_d = !(xfer || (lane_cnt == '0));
  end

  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      acc        <= '0;
      lane_cnt   <= '0;
      flush_pend <= 1'b0;
      out_data   <= '0;
      out_cnt    <= '0;
      out_valid  <= 1'b0;
    end else begin
      acc        <= acc_d;
      lane_cnt   <= lane_cnt_d;
      flush_pend <= flush_pend_d;
      if (xfer) begin
        out_data  <= acc;
        out_cnt   <= lane_cnt;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
